// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and F/D latch payload.
interface fetch_stage_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              stall_in;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       fd_insn;
    logic [31:0]       fd_pc;
    logic              fd_enable;
    logic              fd_valid;

    modport master (
        input  stall_in, redirect_valid, redirect_target, imem_data,
        output imem_addr, fd_insn, fd_pc, fd_enable, fd_valid
    );

    modport slave (
        output stall_in, redirect_valid, redirect_target, imem_data,
        input  imem_addr, fd_insn, fd_pc, fd_enable, fd_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem, holds across stalls,
// inserts bubbles after reset/redirect. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_bubbles
`endif
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {ST_BUBBLE, ST_RUN, ST_HOLD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   hold_q, hold_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [XLEN-1:0]   insn, fd_pc;
    logic              valid, enable;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BUBBLE;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
            hold_q      <= NOP_INSN;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
            hold_q      <= hold_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Next-state and F/D outputs; a redirect overrides both stall and current state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        hold_d      = hold_q;
        hold_pc_d   = hold_pc_q;
        insn        = NOP_INSN;
        fd_pc       = '0;
        valid       = 1'b0;

        if (bus.redirect_valid) begin
            state_d     = ST_BUBBLE;
            pc_d        = bus.redirect_target;
            rsp_valid_d = 1'b0;
            hold_d      = NOP_INSN;
            hold_pc_d   = '0;
        end else begin
            unique case (state_q)
                ST_BUBBLE: begin
                    pc_d        = pc_q + XLEN'(1);
                    rsp_pc_d    = pc_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    insn  = bus.imem_data;
                    fd_pc = rsp_pc_q + XLEN'(1);
                    valid = rsp_valid_q;
                    if (bus.stall_in) begin
                        hold_d    = bus.imem_data;
                        hold_pc_d = rsp_pc_q;
                        state_d   = ST_HOLD;
                    end else begin
                        pc_d     = pc_q + XLEN'(1);
                        rsp_pc_d = pc_q;
                    end
                end
                ST_HOLD: begin
                    insn  = hold_q;
                    fd_pc = hold_pc_q + XLEN'(1);
                    valid = 1'b1;
                    // Re-read of pc_q during the stall returns the word needed next
                    if (!bus.stall_in) begin
                        pc_d        = pc_q + XLEN'(1);
                        rsp_pc_d    = pc_q;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                default: state_d = ST_BUBBLE;
            endcase
        end
    end

    assign enable        = ~bus.stall_in | bus.redirect_valid | (state_q == ST_BUBBLE);
    assign bus.imem_addr = pc_q[ADDR_W-1:0];
    assign bus.fd_insn   = insn;
    assign bus.fd_pc     = fd_pc;
    assign bus.fd_valid  = valid;
    assign bus.fd_enable = enable;

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of delivered instructions and bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (enable && valid && (perf_fetched != '1))
                perf_fetched <= perf_fetched + XLEN'(1);
            if (enable && !valid && (perf_bubbles != '1))
                perf_bubbles <= perf_bubbles + XLEN'(1);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a behavioural 1-cycle-latency imem.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fetch_stage_if #(.ADDR_W(12)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    fetch_stage #(.ADDR_W(12), .RESET_PC(32'd0), .NOP_INSN(32'h0)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    logic [31:0] mem [0:4095];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] e_insn;
        logic [31:0] e_pc;
        logic        e_en;
        logic        e_val;
        logic [11:0] e_addr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_insn, input logic [31:0] e_pc,
                           input logic e_en, input logic e_val, input logic chk_pc);
        chk({tag, ".insn"},   bus.fd_insn, e_insn);
        chk({tag, ".enable"}, 32'(bus.fd_enable), 32'(e_en));
        chk({tag, ".valid"},  32'(bus.fd_valid), 32'(e_val));
        if (chk_pc) chk({tag, ".pc"}, bus.fd_pc, e_pc);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000 + 32'(k);

        //          stall redir target        insn        pc        en   val  addr
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,      32'h0,    1'b1, 1'b0, 12'h000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h1000,   32'h1,    1'b1, 1'b1, 12'h001};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h1001,   32'h2,    1'b1, 1'b1, 12'h002};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h1002,   32'h3,    1'b0, 1'b1, 12'h003};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h1002,   32'h3,    1'b0, 1'b1, 12'h003};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h1002,   32'h3,    1'b0, 1'b1, 12'h003};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h1002,   32'h3,    1'b1, 1'b1, 12'h003};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h1003,   32'h4,    1'b1, 1'b1, 12'h004};
        vecs[8]  = '{1'b0, 1'b1, 32'h40,       32'h0,      32'h0,    1'b1, 1'b0, 12'h005};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,      32'h0,    1'b1, 1'b0, 12'h040};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h1040,   32'h41,   1'b1, 1'b1, 12'h041};
        vecs[11] = '{1'b1, 1'b0, 32'h0,        32'h1041,   32'h42,   1'b0, 1'b1, 12'h042};
        vecs[12] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,     32'h0,    1'b1, 1'b0, 12'h042};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        32'h0,      32'h0,    1'b1, 1'b0, 12'hFFF};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h1FFF,   32'h0,    1'b1, 1'b1, 12'h000};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h1000,   32'h1,    1'b1, 1'b1, 12'h001};

        rst_n               = 1'b0;
        bus.stall_in        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("reset.addr", 32'(bus.imem_addr), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.stall_in        = vecs[i].stall;
            bus.redirect_valid  = vecs[i].redir;
            bus.redirect_target = vecs[i].target;
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_insn, vecs[i].e_pc,
                    vecs[i].e_en, vecs[i].e_val, vecs[i].e_val);
            chk($sformatf("vec%0d.addr", i), 32'(bus.imem_addr), 32'(vecs[i].e_addr));
            @(negedge clk);
        end

`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("perf_fetched", perf_fetched, 32'd7);
        chk("perf_bubbles", perf_bubbles, 32'd5);
`endif

        // Asynchronous reset while holding a stalled instruction
        bus.stall_in        = 1'b1;
        bus.redirect_valid  = 1'b0;
        @(posedge clk);
        #3;
        chk_out("hold_pre_reset", 32'h1001, 32'h2, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("async_reset.addr", 32'(bus.imem_addr), 32'h0);
        @(negedge clk);
        bus.stall_in = 1'b0;
        rst_n        = 1'b1;
        #1;
        chk_out("reboot0", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_out("reboot1", 32'h1000, 32'h1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk_out("reboot2", 32'h1001, 32'h2, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
